// File: rtl/leds_pkg.sv
// Shared types, register map and frame-step helper for the LED sequencer.
package leds_pkg;

    typedef enum logic [1:0] {
        MODE_MANUAL = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    typedef logic [1:0] seq_state_t;
    localparam seq_state_t IDLE = 2'd0;
    localparam seq_state_t LOAD = 2'd1;
    localparam seq_state_t RUN  = 2'd2;

    localparam logic [1:0] ADDR_CTRL    = 2'd0;
    localparam logic [1:0] ADDR_PATTERN = 2'd1;
    localparam logic [1:0] ADDR_PERIOD  = 2'd2;
    localparam logic [1:0] ADDR_STATUS  = 2'd3;

    localparam int CTRL_EN_BIT        = 2;
    localparam int STATUS_RUNNING_BIT = 0;
    localparam int STATUS_DROPPED_BIT = 1;
    localparam int STATUS_DIR_BIT     = 2;
    localparam int STATUS_COUNT_LSB   = 16;

    // Returns {dir, frame} after one step; dir=1 means travelling right.
    function automatic logic [16:0] next_frame(input mode_t mode, input logic [15:0] frame,
                                               input logic [15:0] pattern, input logic dir);
        logic [16:0] r;
        r = {dir, frame};
        case (mode)
            MODE_BLINK:  r[15:0] = (frame == 16'h0000) ? pattern : 16'h0000;
            MODE_ROTATE: r[15:0] = {frame[14:0], frame[15]};
            MODE_BOUNCE: begin
                if ((frame != 16'h0000) && !(frame[15] && frame[0])) begin
                    if (!dir) r = frame[15] ? {1'b1, frame >> 1} : {1'b0, frame << 1};
                    else      r = frame[0]  ? {1'b0, frame << 1} : {1'b1, frame >> 1};
                end
            end
            default: r = {dir, frame};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/leds_prescaler.sv
// Free-running prescaler: counts 0..period-1 and pulses tick on the wrap cycle.
module leds_prescaler
    import leds_pkg::*;
#(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] last;

    // A zero period behaves like one, so the counter ticks every cycle.
    always_comb begin
        last    = (period == '0) ? '0 : period - 1'b1;
        tick    = enable && !clear && (count_q >= last);
        count_d = count_q;
        if (clear)       count_d = '0;
        else if (enable) count_d = tick ? '0 : count_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

endmodule

// File: rtl/leds_sequencer.sv
// LED sequencer: passes CPU LED stores through in MANUAL, otherwise steps an
// autonomous frame engine and reports blocked CPU stores as dropped.
module leds_sequencer
    import leds_pkg::*;
#(
    parameter int               CNT_W          = 24,
    parameter logic [CNT_W-1:0] DEFAULT_PERIOD = CNT_W'(5_000_000)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we_cfg,
    input  logic [1:0]  addr_cfg,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    input  logic        we_cpu_leds,
    input  logic [31:0] cpu_leds_data,
    output logic        we_leds,
    output logic [31:0] leds_data
);

    mode_t            mode_q, mode_d;
    logic             en_q, en_d;
    logic [15:0]      pattern_q, pattern_d;
    logic [CNT_W-1:0] period_q, period_d;
    seq_state_t       state_q, state_d;
    logic [15:0]      frame_q, frame_d;
    logic             dir_q, dir_d;
    logic             dropped_q, dropped_d;
    logic [15:0]      step_cnt_q, step_cnt_d;
    logic             we_leds_q, we_leds_d;
    logic [15:0]      leds_q, leds_d;

    logic wr_ctrl, wr_pattern, wr_period, wr_status;
    logic ctrl_go, restart, tick, presc_run, unused_bits;

    assign presc_run   = (state_q == RUN);
    assign unused_bits = ^{wdata, cpu_leds_data};

    leds_prescaler #(.CNT_W(CNT_W)) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (!presc_run),
        .enable (presc_run),
        .period (period_q),
        .tick   (tick)
    );

    // Any cfg write outranks a tick in the same cycle, so steps only happen on quiet cycles.
    always_comb begin
        wr_ctrl    = we_cfg && (addr_cfg == ADDR_CTRL);
        wr_pattern = we_cfg && (addr_cfg == ADDR_PATTERN);
        wr_period  = we_cfg && (addr_cfg == ADDR_PERIOD);
        wr_status  = we_cfg && (addr_cfg == ADDR_STATUS);
        ctrl_go    = wdata[CTRL_EN_BIT] && (wdata[1:0] != 2'd0);
        restart    = wr_pattern || wr_period || (wr_ctrl && ctrl_go);

        mode_d     = mode_q;
        en_d       = en_q;
        pattern_d  = pattern_q;
        period_d   = period_q;
        state_d    = state_q;
        frame_d    = frame_q;
        dir_d      = dir_q;
        dropped_d  = dropped_q;
        step_cnt_d = step_cnt_q;
        we_leds_d  = 1'b0;
        leds_d     = leds_q;

        if (wr_ctrl) begin
            mode_d = mode_t'(wdata[1:0]);
            en_d   = wdata[CTRL_EN_BIT];
        end
        if (wr_pattern) pattern_d = wdata[15:0];
        if (wr_period)  period_d  = wdata[CNT_W-1:0];
        if (wr_status) begin
            dropped_d  = 1'b0;
            step_cnt_d = 16'h0000;
        end

        case (state_q)
            IDLE: begin
                if (we_cpu_leds) begin
                    we_leds_d = 1'b1;
                    leds_d    = cpu_leds_data[15:0];
                end
                if (wr_ctrl && ctrl_go) state_d = LOAD;
            end
            LOAD, RUN: begin
                if (state_q == LOAD) begin
                    we_leds_d = 1'b1;
                    leds_d    = pattern_q;
                    frame_d   = pattern_q;
                    dir_d     = 1'b0;
                    state_d   = RUN;
                end else if (tick && !we_cfg) begin
                    {dir_d, frame_d} = next_frame(mode_q, frame_q, pattern_q, dir_q);
                    we_leds_d        = 1'b1;
                    leds_d           = frame_d;
                    step_cnt_d       = step_cnt_q + 16'd1;
                end
                if (wr_ctrl && !ctrl_go) state_d = IDLE;
                else if (restart)        state_d = LOAD;
                if (we_cpu_leds) dropped_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q     <= MODE_MANUAL;
            en_q       <= 1'b0;
            pattern_q  <= 16'h0000;
            period_q   <= DEFAULT_PERIOD;
            state_q    <= IDLE;
            frame_q    <= 16'h0000;
            dir_q      <= 1'b0;
            dropped_q  <= 1'b0;
            step_cnt_q <= 16'h0000;
            we_leds_q  <= 1'b0;
            leds_q     <= 16'h0000;
        end else begin
            mode_q     <= mode_d;
            en_q       <= en_d;
            pattern_q  <= pattern_d;
            period_q   <= period_d;
            state_q    <= state_d;
            frame_q    <= frame_d;
            dir_q      <= dir_d;
            dropped_q  <= dropped_d;
            step_cnt_q <= step_cnt_d;
            we_leds_q  <= we_leds_d;
            leds_q     <= leds_d;
        end
    end

    assign we_leds   = we_leds_q;
    assign leds_data = {16'h0000, leds_q};

    always_comb begin
        rdata = '0;
        case (addr_cfg)
            ADDR_CTRL:    rdata[2:0]       = {en_q, mode_q};
            ADDR_PATTERN: rdata[15:0]      = pattern_q;
            ADDR_PERIOD:  rdata[CNT_W-1:0] = period_q;
            default: begin
                rdata[STATUS_RUNNING_BIT]     = (state_q != IDLE);
                rdata[STATUS_DROPPED_BIT]     = dropped_q;
                rdata[STATUS_DIR_BIT]         = dir_q;
                rdata[STATUS_COUNT_LSB +: 16] = step_cnt_q;
            end
        endcase
    end

endmodule

// File: tb/tb_leds_sequencer.sv
// Bench for leds_sequencer: a directed vector table, hand-written multi-cycle
// sequences, and a randomized run compared against a behavioural model.
module tb_leds_sequencer;

    localparam int               CNT_W      = 24;
    localparam logic [CNT_W-1:0] DEF_PERIOD = 24'd5_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        we_cfg = 1'b0;
    logic [1:0]  addr_cfg = 2'd3;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        we_cpu_leds = 1'b0;
    logic [31:0] cpu_leds_data = 32'h0;
    logic        we_leds;
    logic [31:0] leds_data;

    typedef struct {
        logic        we_cfg;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic        we_cpu;
        logic [31:0] cpu_data;
        logic        exp_we;
        logic [31:0] exp_leds;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Behavioural model: run/loading flags plus a countdown to the next step.
    bit m_active, m_loading, m_en, m_dir, m_dropped, m_exp_we;
    int m_mode, m_pattern, m_period, m_frame, m_left, m_steps, m_exp_leds;

    leds_sequencer #(.CNT_W(CNT_W), .DEFAULT_PERIOD(DEF_PERIOD)) dut (
        .clk           (clk),
        .reset         (reset),
        .we_cfg        (we_cfg),
        .addr_cfg      (addr_cfg),
        .wdata         (wdata),
        .rdata         (rdata),
        .we_cpu_leds   (we_cpu_leds),
        .cpu_leds_data (cpu_leds_data),
        .we_leds       (we_leds),
        .leds_data     (leds_data)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        we_cfg        = v.we_cfg;
        addr_cfg      = v.addr;
        wdata         = v.wdata;
        we_cpu_leds   = v.we_cpu;
        cpu_leds_data = v.cpu_data;
        @(posedge clk);
        #1;
        we_cfg      = 1'b0;
        we_cpu_leds = 1'b0;
    endtask

    task automatic step(input string nm, input logic wc, input logic [1:0] a, input logic [31:0] wd,
                        input logic wcpu, input logic [31:0] cd, input logic ewe, input logic [31:0] eleds);
        vec_t v;
        v = '{wc, a, wd, wcpu, cd, ewe, eleds, 1'b0, 32'h0};
        applyStimulus(v);
        checkOutput({nm, ".we"}, {31'b0, we_leds}, {31'b0, ewe});
        checkOutput({nm, ".data"}, leds_data, eleds);
    endtask

    task automatic idle(input string nm, input logic ewe, input logic [31:0] eleds);
        step(nm, 1'b0, 2'd3, 32'h0, 1'b0, 32'h0, ewe, eleds);
    endtask

    task automatic wr(input string nm, input logic [1:0] a, input logic [31:0] wd, input logic [31:0] eleds);
        step(nm, 1'b1, a, wd, 1'b0, 32'h0, 1'b0, eleds);
    endtask

    task automatic readReg(input string nm, input logic [1:0] a, input logic [31:0] expected);
        addr_cfg = a;
        #1;
        checkOutput(nm, rdata, expected);
    endtask

    function automatic int period_cycles();
        return (m_period == 0) ? 1 : m_period;
    endfunction

    task automatic model_advance_frame();
        case (m_mode)
            1: m_frame = (m_frame == 0) ? m_pattern : 0;
            2: m_frame = ((m_frame * 2) % 65536) + (m_frame / 32768);
            3: begin
                if (m_frame != 0 && !(m_frame >= 32768 && m_frame % 2 == 1)) begin
                    if (!m_dir) begin
                        if (m_frame >= 32768) begin m_dir = 1'b1; m_frame = m_frame / 2; end
                        else m_frame = m_frame * 2;
                    end else begin
                        if (m_frame % 2 == 1) begin m_dir = 1'b0; m_frame = m_frame * 2; end
                        else m_frame = m_frame / 2;
                    end
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_cycle(input vec_t v);
        bit was_active, go;
        was_active = m_active;
        m_exp_we   = 1'b0;
        if (m_loading) begin
            m_exp_we   = 1'b1;
            m_exp_leds = m_pattern;
            m_frame    = m_pattern;
            m_dir      = 1'b0;
            m_left     = period_cycles() - 1;
            m_loading  = 1'b0;
        end else if (m_active) begin
            if (m_left == 0) begin
                m_left = period_cycles() - 1;
                if (!v.we_cfg) begin
                    model_advance_frame();
                    m_exp_we   = 1'b1;
                    m_exp_leds = m_frame;
                    m_steps    = (m_steps + 1) % 65536;
                end
            end else begin
                m_left = m_left - 1;
            end
        end else if (v.we_cpu) begin
            m_exp_we   = 1'b1;
            m_exp_leds = int'(v.cpu_data[15:0]);
        end
        if (v.we_cfg) begin
            case (v.addr)
                2'd0: begin
                    go     = v.wdata[2] && (v.wdata[1:0] != 2'd0);
                    m_mode = int'(v.wdata[1:0]);
                    m_en   = v.wdata[2];
                    if (was_active) begin
                        if (go) m_loading = 1'b1;
                        else begin m_active = 1'b0; m_loading = 1'b0; end
                    end else if (go) begin
                        m_active  = 1'b1;
                        m_loading = 1'b1;
                    end
                end
                2'd1: begin m_pattern = int'(v.wdata[15:0]); if (was_active) m_loading = 1'b1; end
                2'd2: begin m_period = int'(v.wdata[23:0]); if (was_active) m_loading = 1'b1; end
                default: begin m_dropped = 1'b0; m_steps = 0; end
            endcase
        end
        if (v.we_cpu && was_active) m_dropped = 1'b1;
    endtask

    function automatic logic [31:0] model_rdata(input logic [1:0] a);
        logic [31:0] st;
        logic [31:0] s;
        st = m_steps;
        case (a)
            2'd0:    s = {29'b0, m_en, st[1:0] & 2'b00 | 2'(m_mode)};
            2'd1:    s = m_pattern;
            2'd2:    s = m_period;
            default: s = {st[15:0], 13'b0, m_dir, m_dropped, m_active};
        endcase
        return s;
    endfunction

    task automatic rcycle(input vec_t v);
        model_cycle(v);
        applyStimulus(v);
        checkOutput("rand.we", {31'b0, we_leds}, {31'b0, m_exp_we});
        checkOutput("rand.data", leds_data, {16'b0, 16'(m_exp_leds)});
        checkOutput("rand.rdata", rdata, model_rdata(v.addr));
    endtask

    initial begin
        vec_t vecs[12];
        vec_t rv;
        logic [31:0] reset_regs[4];

        // MANUAL passthrough, register masking, then a ROTATE start with PERIOD=3.
        vecs[0]  = '{1'b0, 2'd3, 32'h0,         1'b1, 32'hFFFF_A5A5, 1'b1, 32'h0000_A5A5, 1'b1, 32'h0};
        vecs[1]  = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_A5A5, 1'b1, 32'h0};
        vecs[2]  = '{1'b1, 2'd1, 32'hABCD_0001, 1'b0, 32'h0,         1'b0, 32'h0000_A5A5, 1'b1, 32'h1};
        vecs[3]  = '{1'b1, 2'd2, 32'hFF00_0003, 1'b0, 32'h0,         1'b0, 32'h0000_A5A5, 1'b1, 32'h3};
        vecs[4]  = '{1'b1, 2'd0, 32'hFFFF_FFF6, 1'b0, 32'h0,         1'b0, 32'h0000_A5A5, 1'b1, 32'h6};
        vecs[5]  = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0001, 1'b1, 32'h1};
        vecs[6]  = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0001, 1'b0, 32'h0};
        vecs[7]  = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0001, 1'b0, 32'h0};
        vecs[8]  = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0002, 1'b1, 32'h0001_0001};
        vecs[9]  = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0002, 1'b0, 32'h0};
        vecs[10] = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b0, 32'h0000_0002, 1'b0, 32'h0};
        vecs[11] = '{1'b0, 2'd3, 32'h0,         1'b0, 32'h0,         1'b1, 32'h0000_0004, 1'b1, 32'h0002_0001};
        reset_regs[0] = 32'h0;
        reset_regs[1] = 32'h0;
        reset_regs[2] = {8'h0, DEF_PERIOD};
        reset_regs[3] = 32'h0;

        reset = 1'b1;
        idle("reset", 1'b0, 32'h0);
        for (int a = 0; a < 4; a++) readReg("reset.reg", 2'(a), reset_regs[a]);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            checkOutput("vec.we", {31'b0, we_leds}, {31'b0, vecs[i].exp_we});
            checkOutput("vec.data", leds_data, vecs[i].exp_leds);
            if (vecs[i].chk_rd) checkOutput("vec.rdata", rdata, vecs[i].exp_rd);
        end

        // ROTATE keeps going every third cycle; 0x8000 wraps back to 0x0001.
        for (int k = 3; k <= 16; k++) begin
            logic [31:0] prev, nxt;
            prev = 32'h1 << (k - 1);
            nxt  = (k == 16) ? 32'h1 : (32'h1 << k);
            idle("rot.q1", 1'b0, prev);
            idle("rot.q2", 1'b0, prev);
            idle("rot.step", 1'b1, nxt);
        end
        checkOutput("rot.status", rdata, 32'h0010_0001);
        wr("rot.stop", 2'd0, 32'h0, 32'h1);

        // BOUNCE with PERIOD=1: reflects at bit 15, then a full pattern holds.
        wr("bnc.clr", 2'd3, 32'h0, 32'h1);
        wr("bnc.pat", 2'd1, 32'h4000, 32'h1);
        wr("bnc.per", 2'd2, 32'h1, 32'h1);
        wr("bnc.ctrl", 2'd0, 32'h7, 32'h1);
        idle("bnc.load", 1'b1, 32'h4000);
        idle("bnc.s1", 1'b1, 32'h8000);
        idle("bnc.s2", 1'b1, 32'h4000);
        checkOutput("bnc.dir", rdata, 32'h0002_0005);
        idle("bnc.s3", 1'b1, 32'h2000);
        wr("bnc.full", 2'd1, 32'hFFFF, 32'h2000);
        idle("bnc.load2", 1'b1, 32'hFFFF);
        idle("bnc.hold1", 1'b1, 32'hFFFF);
        idle("bnc.hold2", 1'b1, 32'hFFFF);
        checkOutput("bnc.status", rdata, 32'h0005_0001);
        wr("bnc.stop", 2'd0, 32'h3, 32'hFFFF);

        // BLINK with PERIOD=2, blocked CPU store, STATUS clear, PERIOD write on a tick, stop.
        wr("blk.clr", 2'd3, 32'h0, 32'hFFFF);
        wr("blk.pat", 2'd1, 32'h00F0, 32'hFFFF);
        wr("blk.per", 2'd2, 32'h2, 32'hFFFF);
        wr("blk.ctrl", 2'd0, 32'h5, 32'hFFFF);
        idle("blk.load", 1'b1, 32'h00F0);
        idle("blk.q1", 1'b0, 32'h00F0);
        idle("blk.s1", 1'b1, 32'h0000);
        idle("blk.q2", 1'b0, 32'h0000);
        idle("blk.s2", 1'b1, 32'h00F0);
        checkOutput("blk.count", rdata, 32'h0002_0001);
        step("blk.cpu", 1'b0, 2'd3, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 32'h00F0);
        checkOutput("blk.dropped", rdata, 32'h0002_0003);
        wr("blk.stclr", 2'd3, 32'h0, 32'h00F0);
        checkOutput("blk.cleared", rdata, 32'h0000_0001);
        idle("blk.q3", 1'b0, 32'h00F0);
        idle("blk.s3", 1'b1, 32'h0000);
        idle("blk.q4", 1'b0, 32'h0000);
        wr("blk.pertick", 2'd2, 32'h2, 32'h0000);
        idle("blk.reload", 1'b1, 32'h00F0);
        idle("blk.q5", 1'b0, 32'h00F0);
        idle("blk.s4", 1'b1, 32'h0000);
        wr("blk.stop", 2'd0, 32'h1, 32'h0000);
        idle("blk.held1", 1'b0, 32'h0000);
        checkOutput("blk.idle", rdata, 32'h0002_0000);
        idle("blk.held2", 1'b0, 32'h0000);

        // STATUS clear racing a CPU store, then reset right before a tick.
        wr("rst.pat", 2'd1, 32'h00F0, 32'h0000);
        wr("rst.ctrl", 2'd0, 32'h6, 32'h0000);
        idle("rst.load", 1'b1, 32'h00F0);
        step("rst.race", 1'b1, 2'd3, 32'h0, 1'b1, 32'h0000_1111, 1'b0, 32'h00F0);
        checkOutput("rst.setwins", rdata, 32'h0000_0003);
        reset = 1'b1;
        idle("rst.abort", 1'b0, 32'h0);
        reset = 1'b0;
        for (int a = 0; a < 4; a++) readReg("rst.reg", 2'(a), reset_regs[a]);
        idle("rst.quiet", 1'b0, 32'h0);

        // Randomized run against the behavioural model.
        reset = 1'b1;
        idle("rnd.reset", 1'b0, 32'h0);
        reset = 1'b0;
        m_active = 0; m_loading = 0; m_en = 0; m_dir = 0; m_dropped = 0; m_exp_we = 0;
        m_mode = 0; m_pattern = 0; m_period = int'(DEF_PERIOD); m_frame = 0; m_left = 0;
        m_steps = 0; m_exp_leds = 0;
        rv = '{1'b1, 2'd2, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0};
        rcycle(rv);
        for (int n = 0; n < 1500; n++) begin
            int op;
            op          = $urandom_range(0, 23);
            rv.we_cfg   = (op < 4);
            rv.addr     = (op < 4) ? op[1:0] : 2'($urandom_range(0, 3));
            rv.wdata    = (op == 2) ? 32'($urandom_range(0, 4)) : $urandom;
            rv.we_cpu   = ($urandom_range(0, 5) == 0);
            rv.cpu_data = $urandom;
            rcycle(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
